// File: rtl/fp_multiplier_param.sv
// Multi-cycle IEEE-style multiplier, FTZ/DAZ, four rounding modes; FP_MUL_STICKY_FLAGS_EN adds a sticky flag accumulator.
// Result valid 4 cycles after accept and held until out_ready_i; in_ready_o only while idle, one op in flight.
module fp_multiplier_param #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [EXP_W+FRAC_W:0]   x_i,
   input  logic [EXP_W+FRAC_W:0]   y_i,
   input  logic [2:0]              rm_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [EXP_W+FRAC_W:0]   z_o,
   output logic [4:0]              flags_o
`ifdef FP_MUL_STICKY_FLAGS_EN
   ,
   input  logic                    flags_clr_i,
   output logic [4:0]              flags_acc_o
`endif
);

   localparam int W   = 1 + EXP_W + FRAC_W;
   localparam int PW  = 2 * (FRAC_W + 1);
   localparam int EW2 = EXP_W + 2;

   localparam logic signed [EW2-1:0] BIAS_S    = EW2'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW2-1:0] EXP_MAX_S = EW2'((1 << EXP_W) - 1);
   localparam logic signed [EW2-1:0] ZERO_S    = '0;
   localparam logic [W-1:0]          QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MULT  = 3'd1;
   localparam logic [2:0] S_NORM  = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]             state_q;
   logic [W-1:0]           x_q, y_q;
   logic [2:0]             rm_q;
   logic                   sign_q;
   logic signed [EW2-1:0]  exp_q;
   logic [PW-1:0]          prod_q;
   logic                   any_nan_q, any_snan_q, any_inf_q, any_zero_q;
   logic [FRAC_W-1:0]      frac_q;
   logic                   g_q, r_q, s_q, inexact_q;

   logic [EXP_W-1:0]       ex, ey;
   logic [FRAC_W-1:0]      fx, fy;
   logic                   x_max, y_max, x_nan, y_nan;
   logic signed [EW2-1:0]  exp_sum;
   logic [PW-1:0]          prod_c;
   logic [PW-2:0]          pn;
   logic                   rnd_inc, inf_on_ovf;
   logic [FRAC_W:0]        frac_sum;
   logic [W-1:0]           z_c;
   logic [4:0]             f_c;

   assign in_ready_o = (state_q == S_IDLE);

   assign ex      = x_q[W-2:FRAC_W];
   assign ey      = y_q[W-2:FRAC_W];
   assign fx      = x_q[FRAC_W-1:0];
   assign fy      = y_q[FRAC_W-1:0];
   assign x_max   = &ex;
   assign y_max   = &ey;
   assign x_nan   = x_max && (|fx);
   assign y_nan   = y_max && (|fy);
   assign exp_sum = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS_S;
   assign prod_c  = PW'({1'b1, fx}) * PW'({1'b1, fy});

   // Align so the leading one is dropped and frac/G/R/S sit at fixed positions.
   assign pn = prod_q[PW-1] ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};

   always_comb begin
      rnd_inc    = g_q & (r_q | s_q | frac_q[0]);
      inf_on_ovf = 1'b1;
      case (rm_q)
         3'b001: begin rnd_inc = 1'b0;                      inf_on_ovf = 1'b0;    end
         3'b010: begin rnd_inc = sign_q & (g_q | r_q | s_q);  inf_on_ovf = sign_q;  end
         3'b011: begin rnd_inc = ~sign_q & (g_q | r_q | s_q); inf_on_ovf = ~sign_q; end
         default: ;
      endcase
   end

   assign frac_sum = {1'b0, frac_q} + {{FRAC_W{1'b0}}, rnd_inc};

   always_comb begin
      z_c = {sign_q, exp_q[EXP_W-1:0], frac_q};
      f_c = {4'b0000, inexact_q};
      if (any_nan_q) begin
         z_c = QNAN;
         f_c = {any_snan_q, 4'b0000};
      end else if (any_inf_q && any_zero_q) begin
         z_c = QNAN;
         f_c = 5'b10000;
      end else if (any_inf_q) begin
         z_c = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         f_c = 5'b00000;
      end else if (any_zero_q) begin
         z_c = {sign_q, {(W-1){1'b0}}};
         f_c = 5'b00000;
      end else if (exp_q >= EXP_MAX_S) begin
         z_c = inf_on_ovf ? {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                          : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
         f_c = 5'b00101;
      end else if (exp_q <= ZERO_S) begin
         z_c = {sign_q, {(W-1){1'b0}}};
         f_c = 5'b00011;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         rm_q        <= '0;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         prod_q      <= '0;
         any_nan_q   <= 1'b0;
         any_snan_q  <= 1'b0;
         any_inf_q   <= 1'b0;
         any_zero_q  <= 1'b0;
         frac_q      <= '0;
         g_q         <= 1'b0;
         r_q         <= 1'b0;
         s_q         <= 1'b0;
         inexact_q   <= 1'b0;
         out_valid_o <= 1'b0;
         z_o         <= '0;
         flags_o     <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid_i) begin
               x_q     <= x_i;
               y_q     <= y_i;
               rm_q    <= rm_i;
               state_q <= S_MULT;
            end
            S_MULT: begin
               sign_q     <= x_q[W-1] ^ y_q[W-1];
               exp_q      <= exp_sum;
               prod_q     <= prod_c;
               any_nan_q  <= x_nan | y_nan;
               any_snan_q <= (x_nan & ~fx[FRAC_W-1]) | (y_nan & ~fy[FRAC_W-1]);
               any_inf_q  <= x_max | y_max;
               any_zero_q <= (ex == '0) | (ey == '0);
               state_q    <= S_NORM;
            end
            S_NORM: begin
               frac_q  <= pn[PW-2 -: FRAC_W];
               g_q     <= pn[FRAC_W];
               r_q     <= pn[FRAC_W-1];
               s_q     <= |pn[FRAC_W-2:0];
               exp_q   <= exp_q + {{(EW2-1){1'b0}}, prod_q[PW-1]};
               state_q <= S_ROUND;
            end
            S_ROUND: begin
               frac_q    <= frac_sum[FRAC_W-1:0];
               exp_q     <= exp_q + {{(EW2-1){1'b0}}, frac_sum[FRAC_W]};
               inexact_q <= g_q | r_q | s_q;
               state_q   <= S_DONE;
            end
            S_DONE: begin
               // First DONE cycle registers the result; later cycles wait for the consumer.
               if (!out_valid_o) begin
                  out_valid_o <= 1'b1;
                  z_o         <= z_c;
                  flags_o     <= f_c;
               end else if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef FP_MUL_STICKY_FLAGS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         flags_acc_o <= '0;
      else if (flags_clr_i)
         flags_acc_o <= '0;
      else if (out_valid_o && out_ready_i)
         flags_acc_o <= flags_acc_o | flags_o;
   end
`endif

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Randomised + directed bench for fp_multiplier_param (binary32 defaults) against an integer-arithmetic model.
module tb_fp_multiplier_param;

   logic        clk_i = 1'b0;
   logic        rst_ni, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
   logic [31:0] x_i, y_i, z_o;
   logic [2:0]  rm_i;
   logic [4:0]  flags_o;
`ifdef FP_MUL_STICKY_FLAGS_EN
   logic        flags_clr_i;
   logic [4:0]  flags_acc_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   fp_multiplier_param dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .x_i         (x_i),
      .y_i         (y_i),
      .rm_i        (rm_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .z_o         (z_o),
      .flags_o     (flags_o)
`ifdef FP_MUL_STICKY_FLAGS_EN
      ,
      .flags_clr_i (flags_clr_i),
      .flags_acc_o (flags_acc_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Returns {flags, z}. Rounding is decided from the exact discarded remainder against one half ulp.
   function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
      int ea, eb, e, sh;
      longint unsigned ma, mb, p, q, rem, half;
      logic s;
      logic [2:0] m;
      bit inc, nan_a, nan_b, snan, inf_a, inf_b, zero_a, zero_b;
      m  = (rm > 3'd3) ? 3'd0 : rm;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      nan_a  = (ea == 255) && (a[22:0] != 0);
      nan_b  = (eb == 255) && (b[22:0] != 0);
      snan   = (nan_a && !a[22]) || (nan_b && !b[22]);
      inf_a  = (ea == 255) && !nan_a;
      inf_b  = (eb == 255) && !nan_b;
      zero_a = (ea == 0);
      zero_b = (eb == 0);
      if (nan_a || nan_b)                     return {snan, 4'b0000, 32'h7FC0_0000};
      if ((inf_a && zero_b) || (inf_b && zero_a)) return {5'b10000, 32'h7FC0_0000};
      if (inf_a || inf_b)                     return {5'b00000, s, 31'h7F80_0000};
      if (zero_a || zero_b)                   return {5'b00000, s, 31'h0};
      ma = 64'(a[22:0]) + (64'd1 << 23);
      mb = 64'(b[22:0]) + (64'd1 << 23);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e++; end
      else sh = 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      case (m)
         3'd1:    inc = 1'b0;
         3'd2:    inc = s && (rem != 0);
         3'd3:    inc = !s && (rem != 0);
         default: inc = (rem > half) || ((rem == half) && q[0]);
      endcase
      q += 64'(inc);
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin
         if (m == 3'd0 || (m == 3'd3 && !s) || (m == 3'd2 && s)) return {5'b00101, s, 31'h7F80_0000};
         return {5'b00101, s, 31'h7F7F_FFFF};
      end
      if (e <= 0) return {5'b00011, s, 31'h0};
      return {4'b0000, rem != 0, s, 8'(e), q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      int k;
      logic [7:0] e;
      k = $urandom_range(0, 15);
      if (k == 0)      e = 8'h00;
      else if (k == 1) e = 8'hFF;
      else if (k < 10) e = 8'($urandom_range(96, 160));
      else             e = 8'($urandom_range(1, 254));
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   // Called and returns #1 after a rising edge. Holds the result for `hold` cycles with junk on the input side.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m, input int hold,
                         output logic [31:0] z, output logic [4:0] f, output int lat);
      int n;
      x_i = a; y_i = b; rm_i = m; in_valid_i = 1'b1;
      n = 0;
      while (!in_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
      if (!in_ready_o) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0; x_i = $urandom; y_i = $urandom; rm_i = 3'($urandom);
      lat = 0;
      while (!out_valid_o && lat < 20) begin @(posedge clk_i); #1; lat++; end
      z = z_o;
      f = flags_o;
      for (int i = 0; i < hold; i++) begin
         in_valid_i = 1'b1;
         @(posedge clk_i); #1;
         check("hold_z", z_o, z);
         check("hold_flags", 32'(flags_o), 32'(f));
         check("hold_in_ready", 32'(in_ready_o), 32'd0);
         check("hold_out_valid", 32'(out_valid_o), 32'd1);
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      out_ready_i = 1'b0;
   endtask

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  rm;
      logic [31:0] z;
      logic [4:0]  f;
   } vec_t;

   vec_t dir [13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] z;
      logic [4:0]  f;
      logic [36:0] exp_v;
      logic [31:0] xa, yb;
      logic [2:0]  m;
      int lat;
      bit saw_valid;

      dir = '{
         '{32'h3FC0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 5'b00000},
         '{32'h3F80_0001, 32'h3FC0_0000, 3'd0, 32'h3FC0_0002, 5'b00001},
         '{32'h3F80_0001, 32'h3FC0_0000, 3'd1, 32'h3FC0_0001, 5'b00001},
         '{32'h3F80_0001, 32'h3FC0_0000, 3'd3, 32'h3FC0_0002, 5'b00001},
         '{32'hBF80_0001, 32'h3FC0_0000, 3'd2, 32'hBFC0_0002, 5'b00001},
         '{32'h3F80_0001, 32'h3FC0_0000, 3'd5, 32'h3FC0_0002, 5'b00001},
         '{32'h7F00_0000, 32'h7F00_0000, 3'd0, 32'h7F80_0000, 5'b00101},
         '{32'h7F00_0000, 32'h7F00_0000, 3'd1, 32'h7F7F_FFFF, 5'b00101},
         '{32'h7F80_0000, 32'h0000_0000, 3'd0, 32'h7FC0_0000, 5'b10000},
         '{32'hFF80_0000, 32'h4000_0000, 3'd0, 32'hFF80_0000, 5'b00000},
         '{32'h7FA0_0000, 32'h3F80_0000, 3'd0, 32'h7FC0_0000, 5'b10000},
         '{32'h0080_0000, 32'h3F00_0000, 3'd0, 32'h0000_0000, 5'b00011},
         '{32'h0100_0000, 32'h0100_0000, 3'd0, 32'h0000_0000, 5'b00011}
      };

      rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      x_i = '0; y_i = '0; rm_i = '0;
`ifdef FP_MUL_STICKY_FLAGS_EN
      flags_clr_i = 1'b0;
`endif
      #1;
      check("rst_in_ready", 32'(in_ready_o), 32'd1);
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_z", z_o, 32'd0);
      check("rst_flags", 32'(flags_o), 32'd0);
`ifdef FP_MUL_STICKY_FLAGS_EN
      check("rst_flags_acc", 32'(flags_acc_o), 32'd0);
`endif
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(posedge clk_i); #1;

      foreach (dir[i]) begin
         run_op(dir[i].x, dir[i].y, dir[i].rm, (i == 0) ? 10 : 0, z, f, lat);
         check($sformatf("dir%0d_z", i), z, dir[i].z);
         check($sformatf("dir%0d_flags", i), 32'(f), 32'(dir[i].f));
         check($sformatf("dir%0d_lat", i), 32'(lat), 32'd4);
      end

      // Subnormal operand is read as zero: no underflow is raised.
      run_op(32'h0000_0001, 32'h4000_0000, 3'd0, 0, z, f, lat);
      check("daz_z", z, 32'h0000_0000);
      check("daz_flags", 32'(f), 32'd0);
      check("idle_in_ready", 32'(in_ready_o), 32'd1);
      check("idle_out_valid", 32'(out_valid_o), 32'd0);

      for (int i = 0; i < 250; i++) begin
         xa = rand_op();
         yb = rand_op();
         m  = 3'($urandom_range(0, 7));
         run_op(xa, yb, m, $urandom_range(0, 2), z, f, lat);
         exp_v = ref_mul(xa, yb, m);
         check($sformatf("rnd%0d_z x=%08h y=%08h rm=%0d", i, xa, yb, m), z, exp_v[31:0]);
         check($sformatf("rnd%0d_flags", i), 32'(f), 32'(exp_v[36:32]));
         check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd4);
      end

      // Leave a nonzero result on z_o, then reset while the next op is in NORM.
      run_op(32'h3FC0_0000, 32'h4000_0000, 3'd0, 0, z, f, lat);
      x_i = 32'h4000_0000; y_i = 32'h4000_0000; rm_i = 3'd0; in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready_o), 32'd1);
      check("midrst_out_valid", 32'(out_valid_o), 32'd0);
      check("midrst_z", z_o, 32'd0);
      check("midrst_flags", 32'(flags_o), 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i); #1;
         if (out_valid_o) saw_valid = 1'b1;
      end
      check("midrst_no_result", 32'(saw_valid), 32'd0);
      check("midrst_idle", 32'(in_ready_o), 32'd1);

`ifdef FP_MUL_STICKY_FLAGS_EN
      run_op(32'h7F00_0000, 32'h7F00_0000, 3'd0, 0, z, f, lat);
      check("acc_after_ovf", 32'(flags_acc_o), 32'b00101);
      run_op(32'h0080_0000, 32'h3F00_0000, 3'd0, 0, z, f, lat);
      check("acc_after_unf", 32'(flags_acc_o), 32'b00111);
      flags_clr_i = 1'b1;
      run_op(32'h3F80_0001, 32'h3FC0_0000, 3'd0, 0, z, f, lat);
      check("acc_clr_wins", 32'(flags_acc_o), 32'd0);
      flags_clr_i = 1'b0;
      run_op(32'h3F80_0001, 32'h3FC0_0000, 3'd0, 0, z, f, lat);
      check("acc_after_clr", 32'(flags_acc_o), 32'b00001);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
